// File: rtl/cotm32_priv_pkg.sv
// Shared M-mode privilege types: trap causes, CSR ops, CSR addresses and field indices.
package cotm32_priv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MXLEN   = 32;
    localparam int unsigned CAUSE_W = 4;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_INST_ADDR_MISALIGNED  = 4'd0,
        CAUSE_INST_ACCESS_FAULT     = 4'd1,
        CAUSE_ILLEGAL_INST          = 4'd2,
        CAUSE_BREAKPOINT            = 4'd3,
        CAUSE_LOAD_ADDR_MISALIGNED  = 4'd4,
        CAUSE_LOAD_ACCESS_FAULT     = 4'd5,
        CAUSE_STORE_ADDR_MISALIGNED = 4'd6,
        CAUSE_STORE_ACCESS_FAULT    = 4'd7,
        CAUSE_ECALL_U               = 4'd8,
        CAUSE_ECALL_S               = 4'd9,
        CAUSE_ECALL_M               = 4'd11
    } trap_cause_t;

    typedef enum logic [1:0] {
        CSR_OP_WRITE = 2'd0,
        CSR_OP_SET   = 2'd1,
        CSR_OP_CLEAR = 2'd2
    } csr_op_t;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MIE_MEIE       = 11;
    localparam int unsigned MIP_MEIP       = 11;

    localparam logic [CAUSE_W-1:0] IRQ_CODE_M_EXT = 4'd11;

    // Read-modify-write result of a CSR op against the current value.
    function automatic logic [MXLEN-1:0] csr_apply(input csr_op_t op,
                                                   input logic [MXLEN-1:0] old_v,
                                                   input logic [MXLEN-1:0] wdata);
        case (op)
            CSR_OP_SET:   csr_apply = old_v | wdata;
            CSR_OP_CLEAR: csr_apply = old_v & ~wdata;
            default:      csr_apply = wdata;
        endcase
    endfunction

endpackage

// File: rtl/trap_csr_file.sv
// M-mode trap CSR storage, read mux and masked writes.
// COTM32_VECTORED_MTVEC_EN makes mtvec.MODE writable (direct/vectored).
module trap_csr_file
    import cotm32_priv_pkg::*;
#(
    parameter logic [MXLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_trap_en,
    input  logic              i_trap_irq,
    input  logic [XLEN-1:0]   i_pc,
    input  trap_cause_t       i_trap_cause,
    input  logic [MXLEN-1:0]  i_trap_tval,
    input  logic              i_mret_en,
    input  logic              i_csr_we,
    input  csr_op_t           i_csr_op,
    input  logic [11:0]       i_csr_addr,
    input  logic [MXLEN-1:0]  i_csr_wdata,
    input  logic              i_irq_ext,
    output logic [MXLEN-1:0]  o_csr_rdata,
    output logic              o_csr_hit,
    output logic              o_mstatus_mie,
    output logic              o_mie_meie,
    output logic [MXLEN-1:2]  o_mtvec_base,
`ifdef COTM32_VECTORED_MTVEC_EN
    output logic              o_mtvec_vec,
`endif
    output logic [MXLEN-1:2]  o_mepc
);

    localparam logic [MXLEN-1:0] MCAUSE_IRQ = {1'b1, (MXLEN-1-CAUSE_W)'(0), IRQ_CODE_M_EXT};

    logic              mie_q, mpie_q, meie_q;
    logic [MXLEN-1:2]  mtvec_base_q;
    logic [MXLEN-1:2]  mepc_q;
    logic [MXLEN-1:0]  mscratch_q, mcause_q, mtval_q;
    logic [1:0]        mtvec_mode;
    logic [MXLEN-1:0]  wr_val;

`ifdef COTM32_VECTORED_MTVEC_EN
    logic              mtvec_vec_q;
    assign mtvec_mode  = {1'b0, mtvec_vec_q};
    assign o_mtvec_vec = mtvec_vec_q;
`else
    assign mtvec_mode  = 2'b00;
`endif

    // Read mux; also flags whether the address is implemented.
    always_comb begin
        o_csr_rdata = '0;
        o_csr_hit   = 1'b1;
        case (i_csr_addr)
            CSR_MSTATUS: begin
                o_csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                o_csr_rdata[MSTATUS_MPIE] = mpie_q;
                o_csr_rdata[MSTATUS_MIE]  = mie_q;
            end
            CSR_MIE:      o_csr_rdata[MIE_MEIE] = meie_q;
            CSR_MTVEC:    o_csr_rdata = {mtvec_base_q, mtvec_mode};
            CSR_MSCRATCH: o_csr_rdata = mscratch_q;
            CSR_MEPC:     o_csr_rdata = {mepc_q, 2'b00};
            CSR_MCAUSE:   o_csr_rdata = mcause_q;
            CSR_MTVAL:    o_csr_rdata = mtval_q;
            CSR_MIP:      o_csr_rdata[MIP_MEIP] = i_irq_ext;
            default:      o_csr_hit = 1'b0;
        endcase
    end

    assign wr_val = csr_apply(i_csr_op, o_csr_rdata, i_csr_wdata);

    // Trap entry and MRET own the CSRs; software writes only when neither fires.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            meie_q       <= 1'b0;
            mtvec_base_q <= RESET_MTVEC[MXLEN-1:2];
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
`ifdef COTM32_VECTORED_MTVEC_EN
            mtvec_vec_q  <= 1'b0;
`endif
        end else if (i_trap_en) begin
            mepc_q   <= i_pc[XLEN-1:2];
            mcause_q <= i_trap_irq ? MCAUSE_IRQ : {(MXLEN-CAUSE_W)'(0), i_trap_cause};
            mtval_q  <= i_trap_irq ? '0 : i_trap_tval;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (i_mret_en) begin
            mie_q    <= mpie_q;
            mpie_q   <= 1'b1;
        end else if (i_csr_we) begin
            case (i_csr_addr)
                CSR_MSTATUS: begin
                    mie_q  <= wr_val[MSTATUS_MIE];
                    mpie_q <= wr_val[MSTATUS_MPIE];
                end
                CSR_MIE: meie_q <= wr_val[MIE_MEIE];
                CSR_MTVEC: begin
                    mtvec_base_q <= wr_val[MXLEN-1:2];
`ifdef COTM32_VECTORED_MTVEC_EN
                    mtvec_vec_q  <= (wr_val[1:0] == 2'b01);
`endif
                end
                CSR_MSCRATCH: mscratch_q <= wr_val;
                CSR_MEPC:     mepc_q     <= wr_val[MXLEN-1:2];
                CSR_MCAUSE:   mcause_q   <= wr_val;
                CSR_MTVAL:    mtval_q    <= wr_val;
                default: ;
            endcase
        end
    end

    assign o_mstatus_mie = mie_q;
    assign o_mie_meie    = meie_q;
    assign o_mtvec_base  = mtvec_base_q;
    assign o_mepc        = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: event priority, RUN/REDIRECT FSM and registered fetch redirect.
// COTM32_VECTORED_MTVEC_EN enables vectored interrupt targets via mtvec.MODE.
module trap_ctrl
    import cotm32_priv_pkg::*;
#(
    parameter logic [MXLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inst_valid,
    input  logic [XLEN-1:0]   i_pc,
    input  logic              i_trap_req,
    input  trap_cause_t       i_trap_cause,
    input  logic [MXLEN-1:0]  i_trap_tval,
    input  logic              i_mret,
    input  logic              i_irq_ext,
    input  logic              i_csr_en,
    input  csr_op_t           i_csr_op,
    input  logic [11:0]       i_csr_addr,
    input  logic [MXLEN-1:0]  i_csr_wdata,
    output logic [MXLEN-1:0]  o_csr_rdata,
    output logic              o_csr_illegal,
    output logic              o_redirect,
    output logic [XLEN-1:0]   o_redirect_pc,
    output logic              o_irq_taken
);

    typedef enum logic {ST_RUN, ST_REDIRECT} state_t;

    state_t            state_q, state_d;
    logic              redirect_q, redirect_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              irq_taken_q, irq_taken_d;

    logic              take_trap, take_irq, take_mret, csr_we;
    logic              csr_hit, mstatus_mie, mie_meie;
    logic [MXLEN-1:2]  mtvec_base, mepc;
    logic [XLEN-1:0]   trap_base, irq_target;

    assign trap_base = {mtvec_base, 2'b00};

`ifdef COTM32_VECTORED_MTVEC_EN
    localparam logic [XLEN-1:0] IRQ_VEC_OFF = XLEN'(4 * IRQ_CODE_M_EXT);
    logic mtvec_vec;
    assign irq_target = mtvec_vec ? trap_base + IRQ_VEC_OFF : trap_base;
`else
    assign irq_target = trap_base;
`endif

    trap_csr_file #(.RESET_MTVEC(RESET_MTVEC)) u_csr (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_trap_en     (take_trap | take_irq),
        .i_trap_irq    (take_irq),
        .i_pc          (i_pc),
        .i_trap_cause  (i_trap_cause),
        .i_trap_tval   (i_trap_tval),
        .i_mret_en     (take_mret),
        .i_csr_we      (csr_we),
        .i_csr_op      (i_csr_op),
        .i_csr_addr    (i_csr_addr),
        .i_csr_wdata   (i_csr_wdata),
        .i_irq_ext     (i_irq_ext),
        .o_csr_rdata   (o_csr_rdata),
        .o_csr_hit     (csr_hit),
        .o_mstatus_mie (mstatus_mie),
        .o_mie_meie    (mie_meie),
        .o_mtvec_base  (mtvec_base),
`ifdef COTM32_VECTORED_MTVEC_EN
        .o_mtvec_vec   (mtvec_vec),
`endif
        .o_mepc        (mepc)
    );

    // Event priority in RUN: sync trap > interrupt > MRET > CSR write.
    always_comb begin
        state_d       = state_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        irq_taken_d   = 1'b0;
        take_trap     = 1'b0;
        take_irq      = 1'b0;
        take_mret     = 1'b0;
        csr_we        = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (i_trap_req) begin
                    take_trap = 1'b1;
                end else if (i_irq_ext & mie_meie & mstatus_mie & i_inst_valid) begin
                    take_irq = 1'b1;
                end else if (i_mret) begin
                    take_mret = 1'b1;
                end else begin
                    csr_we = i_csr_en;
                end
                if (take_trap | take_irq | take_mret) begin
                    state_d       = ST_REDIRECT;
                    redirect_d    = 1'b1;
                    irq_taken_d   = take_irq;
                    redirect_pc_d = take_mret ? {mepc, 2'b00} :
                                    take_irq  ? irq_target : trap_base;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_RUN;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            irq_taken_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            irq_taken_q   <= irq_taken_d;
        end
    end

    // The pipeline is flushing during REDIRECT, so a CSR access there is not an access.
    assign o_csr_illegal = i_csr_en & ~csr_hit & (state_q == ST_RUN);
    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
    assign o_irq_taken   = irq_taken_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: CSR vector table, directed trap/irq/mret sequences, random vs model.
module tb_trap_ctrl;
    import cotm32_priv_pkg::*;

`ifdef COTM32_VECTORED_MTVEC_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, trap_req, mret, irq_ext, csr_en, csr_illegal, redirect, irq_taken;
    logic [31:0] pc, trap_tval, csr_wdata, csr_rdata, redirect_pc;
    trap_cause_t trap_cause;
    csr_op_t     csr_op;
    logic [11:0] csr_addr;

    trap_ctrl #(.RESET_MTVEC(32'h0000_0100)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(inst_valid), .i_pc(pc),
        .i_trap_req(trap_req), .i_trap_cause(trap_cause), .i_trap_tval(trap_tval),
        .i_mret(mret), .i_irq_ext(irq_ext), .i_csr_en(csr_en), .i_csr_op(csr_op),
        .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata), .o_csr_rdata(csr_rdata),
        .o_csr_illegal(csr_illegal), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
        .o_irq_taken(irq_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        trap;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic [31:0] pc;
        logic        mret;
        logic        irq;
        logic        iv;
        logic        csr_en;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
    } in_t;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        exp_ill;
        logic [11:0] raddr;
        logic [31:0] exp_rd;
    } tv_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state
    bit          m_mie, m_mpie, m_meie, m_redir, m_irq;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_pc;

    logic        s_redir, s_irq, s_ill;
    logic [31:0] s_pc, s_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit impl(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a, input logic irq);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return 32'(m_meie) << 11;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return 32'(irq) << 11;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_redir = 0; m_irq = 0;
        m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_pc = 0;
    endtask

    task automatic model_enter(input in_t v, input bit is_irq);
        logic [31:0] base;
        base     = m_mtvec & ~32'h3;
        m_mepc   = v.pc & ~32'h3;
        m_mcause = is_irq ? 32'h8000_000B : {28'h0, v.cause};
        m_mtval  = is_irq ? 32'h0 : v.tval;
        m_mpie   = m_mie;
        m_mie    = 0;
        m_pc     = (is_irq && VEC && m_mtvec[1:0] == 2'b01) ? base + 32'd44 : base;
        m_irq    = is_irq;
        m_redir  = 1;
    endtask

    task automatic model_step(input in_t v);
        logic [31:0] old_v, nv;
        if (m_redir) begin
            m_redir = 0;
        end else if (v.trap) begin
            model_enter(v, 0);
        end else if (v.irq && m_meie && m_mie && v.iv) begin
            model_enter(v, 1);
        end else if (v.mret) begin
            m_pc = m_mepc; m_irq = 0; m_redir = 1;
            m_mie = m_mpie; m_mpie = 1;
        end else if (v.csr_en && impl(v.addr)) begin
            old_v = model_read(v.addr, v.irq);
            nv = (v.op == 2'd1) ? (old_v | v.wdata) : (v.op == 2'd2) ? (old_v & ~v.wdata) : v.wdata;
            case (v.addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_meie = nv[11];
                12'h305: m_mtvec = (nv & ~32'h3) | ((VEC && nv[1:0] == 2'b01) ? 32'h1 : 32'h0);
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                default: ;
            endcase
        end
    endtask

    // Drive one cycle, compare against model, advance model across the clock edge.
    task automatic cyc(input in_t v);
        inst_valid = v.iv; pc = v.pc; trap_req = v.trap; trap_cause = trap_cause_t'(v.cause);
        trap_tval = v.tval; mret = v.mret; irq_ext = v.irq; csr_en = v.csr_en;
        csr_op = csr_op_t'(v.op); csr_addr = v.addr; csr_wdata = v.wdata;
        #1;
        s_redir = redirect; s_pc = redirect_pc; s_irq = irq_taken; s_rdata = csr_rdata; s_ill = csr_illegal;
        chk("redirect", 32'(redirect), 32'(m_redir));
        if (m_redir) begin
            chk("redirect_pc", redirect_pc, m_pc);
            chk("irq_taken", 32'(irq_taken), 32'(m_irq));
        end
        chk("csr_rdata", csr_rdata, model_read(v.addr, v.irq));
        chk("csr_illegal", 32'(csr_illegal), 32'(!m_redir && v.csr_en && !impl(v.addr)));
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    function automatic in_t idle(input logic [11:0] a);
        in_t v;
        v = '{trap: 0, cause: 0, tval: 0, pc: 0, mret: 0, irq: 0, iv: 1,
              csr_en: 0, op: 0, addr: a, wdata: 0};
        return v;
    endfunction

    function automatic in_t csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        in_t v;
        v = idle(a); v.csr_en = 1; v.op = op; v.wdata = d;
        return v;
    endfunction

    tv_t tbl[16];
    in_t v;
    logic [11:0] addrs[10];

    initial begin
        tbl[0]  = '{2'd1, 12'h304, 32'hFFFF_FFFF, 0, 12'h304, 32'h0000_0800};
        tbl[1]  = '{2'd2, 12'h304, 32'hFFFF_FFFF, 0, 12'h304, 32'h0000_0000};
        tbl[2]  = '{2'd0, 12'h7B0, 32'h0000_1234, 1, 12'h340, 32'h0000_0000};
        tbl[3]  = '{2'd0, 12'h340, 32'hDEAD_BEEF, 0, 12'h340, 32'hDEAD_BEEF};
        tbl[4]  = '{2'd2, 12'h340, 32'h0000_FFFF, 0, 12'h340, 32'hDEAD_0000};
        tbl[5]  = '{2'd1, 12'h340, 32'h0000_000F, 0, 12'h340, 32'hDEAD_000F};
        tbl[6]  = '{2'd0, 12'h300, 32'hFFFF_FFFF, 0, 12'h300, 32'h0000_1888};
        tbl[7]  = '{2'd2, 12'h300, 32'h0000_0008, 0, 12'h300, 32'h0000_1880};
        tbl[8]  = '{2'd0, 12'h344, 32'hFFFF_FFFF, 0, 12'h344, 32'h0000_0000};
        tbl[9]  = '{2'd0, 12'h341, 32'h1234_5677, 0, 12'h341, 32'h1234_5674};
        tbl[10] = '{2'd0, 12'h305, 32'h0000_0203, 0, 12'h305, 32'h0000_0200};
        tbl[11] = '{2'd0, 12'h305, 32'h0000_0101, 0, 12'h305, VEC ? 32'h0000_0101 : 32'h0000_0100};
        tbl[12] = '{2'd0, 12'h7B0, 32'h0000_0000, 1, 12'h340, 32'hDEAD_000F};
        tbl[13] = '{2'd0, 12'h342, 32'h8000_000B, 0, 12'h342, 32'h8000_000B};
        tbl[14] = '{2'd0, 12'h343, 32'h0000_CAFE, 0, 12'h343, 32'h0000_CAFE};
        tbl[15] = '{2'd0, 12'h305, 32'h0000_0100, 0, 12'h305, 32'h0000_0100};
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7B0, 12'h000};

        // Reset
        rst_n = 0;
        v = idle(12'h305);
        inst_valid = 1; pc = 0; trap_req = 0; trap_cause = trap_cause_t'(4'd0); trap_tval = 0;
        mret = 0; irq_ext = 0; csr_en = 0; csr_op = CSR_OP_WRITE; csr_addr = 12'h305; csr_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_redirect", 32'(redirect), 32'h0);
        chk("reset_mtvec", csr_rdata, 32'h100);
        rst_n = 1;
        @(posedge clk);
        #1;

        // CSR op table
        for (int i = 0; i < 16; i++) begin
            cyc(csr(tbl[i].op, tbl[i].addr, tbl[i].wdata));
            chk("tbl_illegal", 32'(s_ill), 32'(tbl[i].exp_ill));
            cyc(idle(tbl[i].raddr));
            chk("tbl_read", s_rdata, tbl[i].exp_rd);
        end

        // Synchronous trap
        cyc(csr(2'd1, 12'h300, 32'h8));
        v = idle(12'h000); v.trap = 1; v.cause = 4'd4; v.tval = 32'h1003; v.pc = 32'h2004;
        cyc(v);
        cyc(idle(12'h341));
        chk("sync_redirect", 32'(s_redir), 32'h1);
        chk("sync_target", s_pc, 32'h100);
        chk("sync_mepc", s_rdata, 32'h2004);
        cyc(idle(12'h342)); chk("sync_mcause", s_rdata, 32'h4);
        cyc(idle(12'h343)); chk("sync_mtval", s_rdata, 32'h1003);
        cyc(idle(12'h300)); chk("sync_mstatus", s_rdata, 32'h1880);

        // External interrupt
        cyc(csr(2'd1, 12'h300, 32'h8));
        cyc(csr(2'd1, 12'h304, 32'h800));
        if (VEC) cyc(csr(2'd0, 12'h305, 32'h101));
        v = idle(12'h000); v.irq = 1; v.pc = 32'h3000;
        cyc(v);
        cyc(idle(12'h342));
        chk("irq_redirect", 32'(s_redir), 32'h1);
        chk("irq_target", s_pc, VEC ? 32'h12C : 32'h100);
        chk("irq_taken", 32'(s_irq), 32'h1);
        chk("irq_mcause", s_rdata, 32'h8000_000B);
        cyc(idle(12'h343)); chk("irq_mtval", s_rdata, 32'h0);
        cyc(idle(12'h341)); chk("irq_mepc", s_rdata, 32'h3000);
        cyc(csr(2'd0, 12'h305, 32'h100));

        // Simultaneous trap + irq + CSR write, then inputs during REDIRECT
        cyc(csr(2'd1, 12'h300, 32'h8));
        v = csr(2'd0, 12'h340, 32'h5A); v.trap = 1; v.cause = 4'd2; v.pc = 32'h4000; v.irq = 1;
        cyc(v);
        v = csr(2'd0, 12'h340, 32'h77); v.trap = 1; v.cause = 4'd5; v.pc = 32'h5000; v.irq = 1;
        cyc(v);
        chk("simul_redirect", 32'(s_redir), 32'h1);
        chk("simul_irq_taken", 32'(s_irq), 32'h0);
        chk("simul_target", s_pc, 32'h100);
        cyc(idle(12'h340));
        chk("simul_no_backtoback", 32'(s_redir), 32'h0);
        chk("simul_mscratch", s_rdata, 32'hDEAD_000F);
        cyc(idle(12'h341)); chk("simul_mepc", s_rdata, 32'h4000);
        cyc(idle(12'h342)); chk("simul_mcause", s_rdata, 32'h2);

        // MRET
        cyc(csr(2'd0, 12'h341, 32'h2008));
        v = idle(12'h000); v.mret = 1;
        cyc(v);
        cyc(idle(12'h300));
        chk("mret_redirect", 32'(s_redir), 32'h1);
        chk("mret_target", s_pc, 32'h2008);
        chk("mret_mstatus", s_rdata, 32'h1888);

        // Reset asserted during REDIRECT
        v = idle(12'h000); v.trap = 1; v.cause = 4'd2; v.pc = 32'h6000;
        cyc(v);
        rst_n = 0;
        #1;
        chk("rst_in_redirect", 32'(redirect), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc(idle(12'h305)); chk("rst_mtvec", s_rdata, 32'h100);
        cyc(idle(12'h341)); chk("rst_mepc", s_rdata, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            v.trap   = ($urandom_range(7) == 0);
            v.cause  = 4'($urandom_range(11));
            v.tval   = $urandom;
            v.pc     = $urandom;
            v.mret   = ($urandom_range(7) == 0);
            v.irq    = 1'($urandom);
            v.iv     = ($urandom_range(3) != 0);
            v.csr_en = 1'($urandom);
            v.op     = 2'($urandom_range(2));
            v.addr   = addrs[$urandom_range(9)];
            v.wdata  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller: the consuming end of the trap-dispatch request. It accepts a prioritised synchronous trap (cause and tval), or a machine external interrupt, or an MRET. It updates the M-mode trap CSRs and issues a registered one-cycle PC redirect to the fetch stage. It also owns the CSR access port for the trap CSR set and sits beside the execute stage, downstream of trap dispatch.

## Interface
- RESET_MTVEC, 32'h0000_0000: reset value of mtvec; bits [1:0] are forced to 0.
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_inst_valid  in  1  instruction in execute is valid this cycle
- i_pc  in  XLEN  PC of the instruction in execute
- i_trap_req  in  1  synchronous trap request
- i_trap_cause  in  trap_cause_t  exception code
- i_trap_tval  in  MXLEN  trap value
- i_mret  in  1  MRET executing
- i_irq_ext  in  1  machine external interrupt, level
- i_csr_en  in  1  CSR access this cycle
- i_csr_op  in  csr_op_t  CSR_OP_WRITE / CSR_OP_SET / CSR_OP_CLEAR
- i_csr_addr  in  12  CSR address
- i_csr_wdata  in  MXLEN  write operand
- o_csr_rdata  out  MXLEN  current CSR value (combinational)
- o_csr_illegal  out  1  i_csr_en with an unimplemented address (combinational)
- o_redirect  out  1  fetch redirect pulse
- o_redirect_pc  out  XLEN  redirect target
- o_irq_taken  out  1  the redirect is an interrupt entry

## Operation
- **Implemented CSRs:**
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11] reads 2'b11; all other bits read 0.
  - mie 0x304: MEIE bit 11 only.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: MEIP bit 11 equals i_irq_ext; read-only, writes ignored.
- **FSM states:** RUN and REDIRECT. Events are accepted only in RUN.
- **Priority within one RUN cycle:** i_trap_req, then interrupt, then i_mret, then CSR write. A higher event suppresses all lower ones, including the CSR write.
- **Interrupt eligibility:** i_irq_ext & mie.MEIE & mstatus.MIE & i_inst_valid & !i_trap_req.
- **Trap entry (sync or interrupt):**
  - mepc <= i_pc & ~3.
  - mcause: sync = {1'b0, 27'b0, i_trap_cause}; interrupt = 32'h8000_000B.
  - mtval: sync = i_trap_tval; interrupt = 0.
  - MPIE <= MIE; MIE <= 0.
  - Target = {mtvec[31:2], 2'b00}.
- **MRET:** MIE <= MPIE; MPIE <= 1; target = mepc.
- **CSR write:** new = wdata / old|wdata / old&~wdata, applied per field masks.
  - Unimplemented address: no write, o_csr_illegal = 1.
  - An illegal-instruction trap is raised by decode, not by this block.
- **On any accepted trap, interrupt or MRET:** FSM goes RUN -> REDIRECT.
  - o_redirect_pc is captured in a register.
  - o_irq_taken is captured in a register.

## Timing
- **Reset values (asynchronous):**
  - State RUN.
  - o_redirect = 0, o_redirect_pc = 0, o_irq_taken = 0.
  - mstatus.MIE = 0, MPIE = 0.
  - mie = 0, mscratch = 0, mepc = 0, mcause = 0, mtval = 0.
  - mtvec = RESET_MTVEC.
- **Event accepted in cycle N:**
  - CSRs update at the end of N.
  - o_redirect = 1 with a valid target during N+1 only.
  - Back in RUN at N+2.
- **REDIRECT cycle:** all inputs ignored, including i_csr_en; the pipeline is flushing. There is no back-to-back redirect.
- **CSR read:** o_csr_rdata is combinational on the pre-write value in the same cycle. A write is visible from N+1.
- **Reset asserted during REDIRECT:** o_redirect drops immediately, with no partial CSR update.
- **Nested trap:** a trap in the first handler instruction overwrites mepc, mcause and mtval; no double-fault detection.

## Configuration
- `COTM32_VECTORED_MTVEC_EN` defined:
  - mtvec.MODE [1:0] is writable; values 0 and 1 are stored, 2 and 3 are stored as 0.
  - With MODE = 1, the interrupt target is BASE + 4*11 (= BASE + 0x2C).
  - Synchronous traps always go to BASE.
- Undefined: MODE is hardwired 0, writes to it are ignored, and all targets are BASE.

## Structure
- **Add to cotm32_priv_pkg:**
  - csr_op_t.
  - CSR address localparams (CSR_MSTATUS, etc.).
  - mstatus bit indices MSTATUS_MIE and MSTATUS_MPIE.
  - MIE_MEIE index.
  - IRQ_CODE_M_EXT = 11.
- **Reuse** trap_cause_t.
- **One sub-module:** trap_csr_file, which holds the CSR registers, the read mux and the write masking. trap_ctrl holds the FSM, event priority and redirect registers.

## Test plan
- **Reset:** after reset, mtvec = RESET_MTVEC (0x100) and o_redirect = 0.
- **Synchronous trap:** i_trap_req, cause LOAD_ADDR_MISALIGNED (4), tval 0x1003, i_pc 0x2004, MIE = 1 -> at N+1:
  - o_redirect = 1 to 0x100.
  - mepc = 0x2004, mcause = 4, mtval = 0x1003.
  - MIE = 0, MPIE = 1.
- **Interrupt:** MIE = 1, MEIE = 1, i_irq_ext = 1, i_pc 0x3000 -> mcause = 0x8000000B, mtval = 0, mepc = 0x3000, o_irq_taken = 1.
  - With the macro and mtvec = 0x101: target 0x12C.
  - Without the macro: target 0x100.
- **Simultaneous events:** i_trap_req + i_irq_ext + CSR write to mscratch (0x5A) in one cycle -> sync trap taken, mscratch unchanged, the cycle after redirect ignores inputs.
- **MRET:** mepc = 0x2008, MPIE = 1, MIE = 0 -> redirect to 0x2008, MIE = 1, MPIE = 1.
- **CSR ops:** SET mie 0xFFFFFFFF -> reads 0x800; CLEAR -> 0; write 0x7B0 -> o_csr_illegal = 1, no state change.
